servo_ramp_ctrl: RTL

Upstream command stage for servo_driver. Accepts target positions over a valid/ready handshake and produces the duty_level bus (0..1000) that servo_driver consumes. Slews duty_level toward the target by at most STEP_MAX units per 20 ms frame, so the servo never receives a step command. The frame timer matches servo_driver's frame length, so duty changes are applied once per PWM frame.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_frame_timer.sv | 27 ++
 rtl/servo_ramp_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared widths, defaults and state encoding for the servo command path.
package servo_pkg;

    localparam int DUTY_W        = 10;
    localparam int DUTY_MAX_C    = 1000;
    localparam int FRAME_TICKS_C = 1_000_000;

    // Ramp direction; informational only, it feeds the busy flag.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } servo_state_e;

    // Saturate a requested duty level to the configured ceiling.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                     input logic [DUTY_W-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick marks the last clock of each frame.
// Sharing reset with servo_driver keeps both frame boundaries aligned.
import servo_pkg::*;

module servo_frame_timer #(
    parameter int FRAME_TICKS = FRAME_TICKS_C
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int              CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    assign frame_tick = (cnt == LAST);

    // Count 0..FRAME_TICKS-1 and wrap, giving a period of exactly FRAME_TICKS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (frame_tick) cnt <= '0;
        else                 cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Target command stage for servo_driver: buffers one pending target and slews
// duty_level toward it by at most STEP_MAX per frame, so the servo never sees
// a step change.
import servo_pkg::*;

module servo_ramp_ctrl #(
    parameter int FRAME_TICKS = FRAME_TICKS_C,
    parameter int STEP_MAX    = 20,
    parameter int DUTY_MAX    = DUTY_MAX_C,
    parameter int DUTY_INIT   = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic              hold,
    output logic [DUTY_W-1:0] duty_level,
    output logic              frame_tick,
    output logic              at_target,
    output logic              busy
);

    localparam int                     DW1    = DUTY_W + 1;
    localparam logic [DUTY_W-1:0]      DMAX_V = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]      INIT_V = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W-1:0]      STEP_V = DUTY_W'(STEP_MAX);
    localparam logic signed [DUTY_W:0] STEP_S = DW1'(STEP_MAX);

    logic [DUTY_W-1:0]      target, pend_val, eff_target, duty_nxt;
    logic                   pend_valid, accept, upd;
    logic signed [DUTY_W:0] diff;
    servo_state_e           state, state_nxt;

    servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    assign cmd_ready = ~pend_valid;
    assign accept    = cmd_valid & cmd_ready;
    assign upd       = frame_tick & ~hold;
    assign at_target = (duty_level == target) & ~pend_valid;
    assign busy      = (state != IDLE) | pend_valid;

    // Next duty: jump to the goal when within one step, else move one step.
    // Both operands lie in 0..DUTY_MAX, so the result cannot leave that range.
    always_comb begin
        eff_target = pend_valid ? pend_val : target;
        diff       = $signed({1'b0, eff_target}) - $signed({1'b0, duty_level});
        if (diff > STEP_S)       duty_nxt = duty_level + STEP_V;
        else if (diff < -STEP_S) duty_nxt = duty_level - STEP_V;
        else                     duty_nxt = eff_target;
        if (duty_nxt == eff_target)     state_nxt = IDLE;
        else if (duty_nxt < eff_target) state_nxt = RAMP_UP;
        else                            state_nxt = RAMP_DOWN;
    end

    // Frame update: load the pending target and apply one slew step together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_level <= INIT_V;
            target     <= INIT_V;
            state      <= IDLE;
        end else if (upd) begin
            duty_level <= duty_nxt;
            target     <= eff_target;
            state      <= state_nxt;
        end
    end

    // Pending slot: an accept on a tick cycle lands here and waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_val   <= INIT_V;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_val   <= clamp_duty(cmd_target, DMAX_V);
        end else if (upd) begin
            pend_valid <= 1'b0;
        end
    end

endmodule
